// File: rtl/gs_butterfly_intt.sv
// Four-stage Gentleman-Sande butterfly for the Kyber inverse NTT (q = 3329): c = a + b, d = (a - b) * wn.
// Define INTT_HALVE_EN to scale both outputs by 2^-1 mod q in the last stage.
module gs_butterfly_intt (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [11:0] wn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] c,
    output logic [11:0] d
);
    localparam int        Q   = 3329;
    localparam int        LAT = 4;
    localparam logic [12:0] Q13 = 13'd3329;

    logic en;

    logic        v1_reg, v2_reg, v3_reg, out_valid_reg;
    logic [12:0] sum_reg;
    logic [11:0] diff_reg, wn_reg;
    logic [11:0] c2_reg;
    logic [23:0] p_reg;
    logic [13:0] r_reg;
    logic [11:0] c3_reg;
    logic [11:0] c_reg, d_reg;

    logic [12:0] sum_next;
    logic [11:0] diff_next;
    logic [11:0] c2_next;
    logic [23:0] p_next;
    logic [13:0] r_next;
    logic [12:0] fold;
    logic [12:0] x;
    logic [11:0] d_red;
    logic [11:0] c_next, d_next;

    // Residues of h*2^20, m*2^16 and l*2^12 for the split-LUT product reduction.
    logic [13:0] rom_h [16];
    logic [13:0] rom_m [16];
    logic [13:0] rom_l [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rom
            assign rom_h[gi] = 14'((gi * (1 << 20)) % Q);
            assign rom_m[gi] = 14'((gi * (1 << 16)) % Q);
            assign rom_l[gi] = 14'((gi * (1 << 12)) % Q);
        end
    endgenerate

    assign en        = out_ready | ~out_valid_reg;
    assign in_ready  = en;
    assign out_valid = out_valid_reg;
    assign c         = c_reg;
    assign d         = d_reg;

    assign sum_next  = {1'b0, a} + {1'b0, b};
    // The 12-bit wrap of (a - b) + q is exact because the true result is below q.
    assign diff_next = (a < b) ? (a - b) + 12'd3329 : a - b;

    assign c2_next = (sum_reg >= Q13) ? 12'(sum_reg - Q13) : sum_reg[11:0];
    assign p_next  = 24'(diff_reg) * 24'(wn_reg);

    assign r_next = rom_h[p_reg[23:20]] + rom_m[p_reg[19:16]] + rom_l[p_reg[15:12]]
                  + {2'b00, p_reg[11:0]};

    always_comb begin
        fold = 13'd0;
        case (r_reg[13:12])
            2'd0: fold = 13'd0;
            2'd1: fold = 13'd767;
            2'd2: fold = 13'd1534;
            2'd3: fold = 13'd2301;
            default: fold = 13'd0;
        endcase
    end

    assign x     = {1'b0, r_reg[11:0]} + fold;
    assign d_red = (x >= Q13) ? 12'(x - Q13) : x[11:0];

`ifdef INTT_HALVE_EN
    // Multiply by 2^-1 mod q: odd values borrow one q to become even first.
    function automatic logic [11:0] halve(input logic [11:0] v);
        logic [12:0] t;
        t = v[0] ? ({1'b0, v} + Q13) : {1'b0, v};
        return t[12:1];
    endfunction

    assign c_next = halve(c3_reg);
    assign d_next = halve(d_red);
`else
    assign c_next = c3_reg;
    assign d_next = d_red;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            v3_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            c_reg         <= 12'd0;
            d_reg         <= 12'd0;
        end else if (en) begin
            v1_reg        <= in_valid;
            v2_reg        <= v1_reg;
            v3_reg        <= v2_reg;
            out_valid_reg <= v3_reg;
            c_reg         <= c_next;
            d_reg         <= d_next;
        end
    end

    // Datapath registers need no reset; the valid chain qualifies them.
    always_ff @(posedge clk) begin
        if (en) begin
            sum_reg  <= sum_next;
            diff_reg <= diff_next;
            wn_reg   <= wn;
            c2_reg   <= c2_next;
            p_reg    <= p_next;
            r_reg    <= r_next;
            c3_reg   <= c2_reg;
        end
    end

endmodule

// File: tb/tb_gs_butterfly_intt.sv
// Self-checking bench for gs_butterfly_intt: directed corner beats, random full-rate stream,
// backpressure and mid-stream reset, scored against a plain modular-arithmetic model.
module tb_gs_butterfly_intt;
    localparam int Q = 3329;
`ifdef INTT_HALVE_EN
    localparam bit HALVE = 1'b1;
`else
    localparam bit HALVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a, b, wn;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] c, d;

    typedef struct {
        int c;
        int d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   n0;
    int   vcount;
    logic drv_acc;
    logic [11:0] hold_c, hold_d;

    gs_butterfly_intt dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .wn       (wn),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c),
        .d        (d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: 2^-1 mod 3329 is 1665.
    function automatic int scale(int v);
        return HALVE ? (v * 1665) % Q : v;
    endfunction

    function automatic exp_t model(int av, int bv, int wv);
        exp_t e;
        e.c = scale((av + bv) % Q);
        e.d = scale(((av - bv + Q) % Q * wv) % Q);
        return e;
    endfunction

    // Scoreboard: signals are stable at the falling edge, so a handshake seen here
    // is the transfer that happens at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_c", c, mon_e.c);
                    check("out_d", d, mon_e.d);
                    n_out++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, wn));
        end
    end

    // One beat from an idle pipeline: not visible after 3 edges, visible after 4.
    task automatic send_directed(input string tag, input int av, input int bv, input int wv,
                                 input int ec, input int ed);
        @(posedge clk); #1;
        a = 12'(av); b = 12'(bv); wn = 12'(wv); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_early"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_c"}, c, ec);
        check({tag, "_d"}, d, ed);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 12'd0; b = 12'd0; wn = 12'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_d", d, 0);
        check("rst_in_ready", in_ready, 1);

        send_directed("t_5_3", 5, 3, 1, HALVE ? 4 : 8, HALVE ? 1 : 2);
        send_directed("t_3_5", 3, 5, 1, HALVE ? 4 : 8, HALVE ? 3328 : 3327);
        send_directed("t_max", 3328, 3328, 3328, scale(3327), scale(0));
        send_directed("t_maxprod", 3328, 0, 3328, scale(3328), scale(1));

        // Random full-rate stream: the last output must leave 4 edges after the last accept.
        repeat (3) @(posedge clk);
        #1;
        n0 = n_out;
        for (int i = 0; i < 1000; i++) begin
            a = 12'($urandom_range(0, Q - 1));
            b = 12'($urandom_range(0, Q - 1));
            wn = 12'($urandom_range(0, Q - 1));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rand_drained", exp_q.size(), 0);
        check("rand_count", n_out - n0, 1000);

        // Six beats with out_ready low for three cycles once outputs are flowing.
        n0 = n_out;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = 12'($urandom_range(0, Q - 1));
                    b = 12'($urandom_range(0, Q - 1));
                    wn = 12'($urandom_range(0, Q - 1));
                    in_valid = 1'b1;
                    drv_acc = 1'b0;
                    for (int t = 0; t < 20 && !drv_acc; t++) begin
                        @(negedge clk);
                        drv_acc = in_ready;
                        @(posedge clk); #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                hold_c = c; hold_d = d;
                check("stall_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("stall_hold_c", c, hold_c);
                    check("stall_hold_d", d, hold_d);
                    check("stall_hold_valid", out_valid, 1);
                    check("stall_hold_ready", in_ready, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
            @(negedge clk); #1;
        end
        check("stall_drained", exp_q.size(), 0);
        check("stall_count", n_out - n0, 6);

        // Reset with one beat at the output and two still in flight.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            a = 12'(100 + i); b = 12'(200 + i); wn = 12'(7 + i);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_c", c, 0);
        check("midrst_d", d, 0);
        check("midrst_in_ready", in_ready, 1);
        vcount = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("midrst_no_stale", vcount, 0);
        send_directed("t_after_rst", 1, 1, 1, scale(2), scale(0));
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
